// File: rtl/l1ca_code_nco.sv
// Code-rate NCO and early/prompt/late replica stage for one L1 C/A tracking channel.
// Optional epoch snapshot registers are built when L1CA_NCO_SNAPSHOT_EN is defined.
module l1ca_code_nco #(
    parameter int ACC_W = 32
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             start,
    input  logic             stop,
    input  logic [ACC_W-1:0] phase_init,
    input  logic [ACC_W-1:0] fcw,
    input  logic             fcw_valid,
    output logic             fcw_ready,
    input  logic             code_in,
    input  logic             epoch_in,
    input  logic [9:0]       chip_in,
    output logic             gen_en,
    output logic             gen_clear,
    output logic             early,
    output logic             prompt,
    output logic             late,
    output logic             epl_valid,
    output logic             strobe,
    output logic             prompt_epoch,
    output logic [4:0]       ms_cnt,
    output logic [9:0]       snap_chip,
    output logic [ACC_W-1:0] snap_phase,
    output logic [1:0]       dbg_state
);

    // fcw handshake: a word transfers on a rising clk edge where fcw_valid && fcw_ready;
    // fcw_ready depends only on state, never on fcw_valid.
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CLEAR = 2'd1,
        S_PRIME = 2'd2,
        S_RUN   = 2'd3
    } state_e;

    localparam logic [ACC_W-1:0] FCW_MAX = {2'b01, {(ACC_W-2){1'b0}}};

    state_e           state_q, state_d;
    logic [1:0]       prime_cnt_q, prime_cnt_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] fcw_q, fcw_d;
    logic             gen_en_q, gen_en_d;
    logic             h1_q, h1_d;
    logic             samp_q, samp_d;
    logic             strobe_q, strobe_d;
    logic [2:0]       code_sr_q, code_sr_d;
    logic [2:0]       epoch_sr_q, epoch_sr_d;
    logic [4:0]       ms_q, ms_d;

    logic [ACC_W:0]   sum;
    logic             carry;
    logic             raw_half;
    logic             active;
    logic             adv;
    logic             pe;

    always_comb begin
        state_d     = state_q;
        prime_cnt_d = prime_cnt_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_CLEAR;
            S_CLEAR: begin
                state_d     = S_PRIME;
                prime_cnt_d = 2'd0;
            end
            S_PRIME: begin
                if (strobe_q) begin
                    if (prime_cnt_q == 2'd2) state_d = S_RUN;
                    else                     prime_cnt_d = prime_cnt_q + 2'd1;
                end
            end
            S_RUN:   if (start) state_d = S_CLEAR;
            default: state_d = S_IDLE;
        endcase
        if (stop) state_d = S_IDLE;
    end

    // The pipeline only advances when this cycle and the next are both tracking, so an
    // in-flight sample is dropped on stop/restart instead of landing in IDLE or CLEAR.
    always_comb begin
        active   = (state_q == S_PRIME) || (state_q == S_RUN);
        adv      = active && ((state_d == S_PRIME) || (state_d == S_RUN));
        sum      = {1'b0, acc_q} + {1'b0, fcw_q};
        carry    = sum[ACC_W];
        raw_half = carry | (~acc_q[ACC_W-1] & sum[ACC_W-1]);
        pe       = strobe_q & epoch_sr_q[1] & ~epoch_sr_q[2] & (state_q == S_RUN);

        acc_d      = acc_q;
        gen_en_d   = 1'b0;
        h1_d       = 1'b0;
        samp_d     = 1'b0;
        strobe_d   = 1'b0;
        code_sr_d  = code_sr_q;
        epoch_sr_d = epoch_sr_q;
        ms_d       = ms_q;

        if (pe) ms_d = (ms_q == 5'd19) ? 5'd0 : ms_q + 5'd1;

        if (state_q == S_CLEAR) begin
            acc_d      = phase_init;
            code_sr_d  = 3'b000;
            epoch_sr_d = 3'b000;
            ms_d       = 5'd0;
        end else if (adv) begin
            acc_d    = sum[ACC_W-1:0];
            gen_en_d = carry;
            h1_d     = raw_half;
            samp_d   = h1_q;
            strobe_d = samp_q;
            if (samp_q) begin
                code_sr_d  = {code_sr_q[1:0], code_in};
                epoch_sr_d = {epoch_sr_q[1:0], epoch_in};
            end
        end
    end

    always_comb begin
        fcw_ready = (state_q == S_IDLE) || (state_q == S_RUN);
        fcw_d     = fcw_q;
        if (fcw_valid && fcw_ready) fcw_d = (fcw > FCW_MAX) ? FCW_MAX : fcw;
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= S_IDLE;
            prime_cnt_q <= 2'd0;
            acc_q       <= '0;
            fcw_q       <= '0;
            gen_en_q    <= 1'b0;
            h1_q        <= 1'b0;
            samp_q      <= 1'b0;
            strobe_q    <= 1'b0;
            code_sr_q   <= 3'b000;
            epoch_sr_q  <= 3'b000;
            ms_q        <= 5'd0;
        end else begin
            state_q     <= state_d;
            prime_cnt_q <= prime_cnt_d;
            acc_q       <= acc_d;
            fcw_q       <= fcw_d;
            gen_en_q    <= gen_en_d;
            h1_q        <= h1_d;
            samp_q      <= samp_d;
            strobe_q    <= strobe_d;
            code_sr_q   <= code_sr_d;
            epoch_sr_q  <= epoch_sr_d;
            ms_q        <= ms_d;
        end
    end

`ifdef L1CA_NCO_SNAPSHOT_EN
    logic [9:0]       snap_chip_q, snap_chip_d;
    logic [ACC_W-1:0] snap_phase_q, snap_phase_d;

    always_comb begin
        snap_chip_d  = snap_chip_q;
        snap_phase_d = snap_phase_q;
        if (pe) begin
            snap_chip_d  = chip_in;
            snap_phase_d = acc_q;
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            snap_chip_q  <= 10'd0;
            snap_phase_q <= '0;
        end else begin
            snap_chip_q  <= snap_chip_d;
            snap_phase_q <= snap_phase_d;
        end
    end

    assign snap_chip  = snap_chip_q;
    assign snap_phase = snap_phase_q;
`else
    logic unused_chip;
    assign unused_chip = ^chip_in;
    assign snap_chip   = 10'd0;
    assign snap_phase  = '0;
`endif

    assign gen_clear    = (state_q == S_CLEAR);
    assign gen_en       = gen_en_q;
    assign strobe       = strobe_q;
    assign early        = code_sr_q[0];
    assign prompt       = code_sr_q[1];
    assign late         = code_sr_q[2];
    assign epl_valid    = (state_q == S_RUN);
    assign prompt_epoch = pe;
    assign ms_cnt       = ms_q;
    assign dbg_state    = state_q;

endmodule
